// File: rtl/instr_store.sv
// instr_store: byte-loaded instruction memory serving registered fetches to the processor.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   load_start       - one-cycle pulse beginning a full reload
//   load_valid/byte  - byte-serial load data, MSB first within each word
//   load_ready       - a byte is accepted this cycle when load_valid is also high
//   load_done        - one-cycle pulse when the last word has been written
//   words_loaded     - complete words written in the current load
//   address          - fetch address from the processor
//   instruction      - registered fetch data, forced to 0 (NOP) while loading
//   busy             - high while loading
module instr_store #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept, word_done, final_word;

    assign busy       = state == LOAD;
    // A restart pulse blocks acceptance so a byte offered with it is dropped.
    assign load_ready = busy && !load_start;
    assign accept     = load_valid && load_ready;
    assign word_done  = accept && byte_cnt == 2'd3;
    assign final_word = word_done && wr_ptr == LAST;

    always_comb begin
        state_nxt = load_start ? LOAD : final_word ? RUN : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            byte_cnt     <= '0;
            wr_ptr       <= '0;
            words_loaded <= '0;
            sh           <= '0;
            load_done    <= 1'b0;
            instruction  <= '0;
        end else begin
            load_done   <= final_word;
            // Memory is read with the pre-edge state, so the final-byte edge still returns 0.
            instruction <= busy ? '0 : mem[address];
            if (load_start) begin
                byte_cnt     <= '0;
                wr_ptr       <= '0;
                words_loaded <= '0;
                sh           <= '0;
            end else if (accept) begin
                sh       <= {sh[DATA_W-9:0], load_byte};
                byte_cnt <= byte_cnt + 2'd1;
                if (word_done) begin
                    mem[wr_ptr]  <= {sh[DATA_W-9:0], load_byte};
                    wr_ptr       <= wr_ptr + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_store.sv
// tb_instr_store: randomized and directed checks of instr_store against a word-level reference model.
module tb_instr_store;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    logic              clk = 0, rst_n = 0, load_start = 0, load_valid = 0;
    logic [7:0]        load_byte = 0;
    logic [ADDR_W-1:0] address = 0;
    logic              load_ready, load_done, busy;
    logic [ADDR_W:0]   words_loaded;
    logic [DATA_W-1:0] instruction;

    instr_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(load_ready), .load_done(load_done),
        .words_loaded(words_loaded), .address(address), .instruction(instruction), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, errs = 0;

    // Reference: memory contents, whether a load is in progress, bytes taken in this load.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                loading;
    int                nbytes;
    logic [7:0]        part[$];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        loading = 0;
        nbytes  = 0;
        part.delete();
    endtask

    function automatic logic [ADDR_W-1:0] ra();
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    // Apply one cycle of inputs, advance the model by one edge, compare all outputs.
    task automatic cycle(input bit ls, input bit lv, input logic [7:0] lb, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] e_instr;
        bit                e_done;
        load_start = ls;
        load_valid = lv;
        load_byte  = lb;
        address    = a;
        e_instr = loading ? '0 : ref_mem[a];
        e_done  = 0;
        if (ls) begin
            loading = 1;
            nbytes  = 0;
            part.delete();
        end else if (loading && lv) begin
            part.push_back(lb);
            nbytes++;
            if (part.size() == 4) begin
                ref_mem[nbytes/4 - 1] = {part[0], part[1], part[2], part[3]};
                part.delete();
            end
            if (nbytes == 4*DEPTH) begin
                loading = 0;
                e_done  = 1;
            end
        end
        @(posedge clk); #1;
        check("instruction", instruction, e_instr);
        check("load_done", 32'(load_done), 32'(e_done));
        check("busy", 32'(busy), 32'(loading));
        check("load_ready", 32'(load_ready), 32'(loading && !ls));
        check("words_loaded", 32'(words_loaded), 32'(nbytes/4));
    endtask

    task automatic do_reset();
        load_start = 0;
        load_valid = 0;
        rst_n = 0;
        #2;
        check("rst_instruction", instruction, '0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_words_loaded", 32'(words_loaded), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_load_ready", 32'(load_ready), 0);
        clear_model();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) cycle(0, 0, 8'($urandom), ra());
        cycle(0, 1, b, ra());
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    endtask

    task automatic sweep();
        for (int a = 0; a < DEPTH; a++) cycle(0, 0, 8'($urandom), ADDR_W'(a));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        repeat (2) cycle(0, 0, 8'h00, 3'd5);
        cycle(0, 1, 8'hAA, 3'd5);
        // Full load with word k = 0x10000000+k, then fetch word 3 and every address.
        cycle(1, 0, 8'h00, 3'd0);
        for (int k = 0; k < DEPTH; k++) send_word(32'h1000_0000 + k, 0);
        cycle(0, 0, 8'h00, 3'd3);
        sweep();
        // Byte gaps between the bytes of word 0.
        cycle(1, 0, 8'h00, ra());
        send_word(32'hF012_3456, 2);
        for (int k = 1; k < DEPTH; k++) send_word($urandom, 0);
        sweep();
        // Restart mid-word with a byte offered alongside the restart.
        cycle(1, 0, 8'h00, ra());
        send_word($urandom, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        cycle(1, 1, 8'h77, ra());
        for (int k = 0; k < DEPTH; k++) send_word(32'hA500_0000 + k, $urandom_range(0, 1));
        sweep();
        // Bytes offered while serving are ignored.
        repeat (8) cycle(0, 1, 8'($urandom), ra());
        sweep();
        // Restart on the final byte: no write, no done pulse.
        cycle(1, 0, 8'h00, ra());
        for (int k = 0; k < DEPTH - 1; k++) send_word($urandom, 0);
        repeat (3) send_byte(8'($urandom), 0);
        cycle(1, 1, 8'h5A, ra());
        for (int k = 0; k < DEPTH; k++) send_word($urandom, 0);
        sweep();
        // Reset mid-load leaves memory all-zero.
        cycle(1, 0, 8'h00, ra());
        for (int k = 0; k < 3; k++) send_word($urandom, 0);
        do_reset();
        sweep();
        // Random traffic.
        cycle(1, 0, 8'h00, ra());
        repeat (1500) cycle($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), 8'($urandom), ra());
        sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
